// File: rtl/sdram_line_xfer_if.sv
// Request, SDRAM command/data and line-buffer signals of the SDRAM line transfer engine.
// The master modport is the engine's view; the slave modport is its environment's view.
interface sdram_line_xfer_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int SDRAM_AW   = 24
);
  logic                  fill_req;
  logic                  wb_req;
  logic [SDRAM_AW-1:0]   line_addr;
  logic                  fill_ack;
  logic                  wb_ack;
  logic                  busy;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [SDRAM_AW-1:0]   cmd_addr;

  logic                  rd_valid;
  logic [15:0]           rd_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [15:0]           wr_data;

  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [3:0]            buf_we;
  logic [31:0]           buf_di;
  logic [31:0]           buf_do;

  modport master (
    input  fill_req, wb_req, line_addr, cmd_ready, rd_valid, rd_data, wr_ready, buf_do,
    output fill_ack, wb_ack, busy, cmd_valid, cmd_we, cmd_addr, wr_valid, wr_data,
           buf_addr, buf_we, buf_di
  );

  modport slave (
    output fill_req, wb_req, line_addr, cmd_ready, rd_valid, rd_data, wr_ready, buf_do,
    input  fill_ack, wb_ack, busy, cmd_valid, cmd_we, cmd_addr, wr_valid, wr_data,
           buf_addr, buf_we, buf_di
  );
endinterface

// File: rtl/sdram_line_xfer.sv
// SDRAM-side burst engine for one cache line: fills the 32-bit line buffer from 16-bit
// read beats, or streams the buffered line back to SDRAM as 16-bit write beats.
module sdram_line_xfer #(
  parameter int ADDR_WIDTH = 3,
  parameter int SDRAM_AW   = 24
) (
  input logic                sdram_clk,
  input logic                sdram_rst_n,
  sdram_line_xfer_if.master  bus
);

  localparam int BC_W = ADDR_WIDTH + 1;
  localparam int OFF  = ADDR_WIDTH + 2;
  localparam logic [SDRAM_AW-1:0] LOW_MASK = SDRAM_AW'((64'd1 << OFF) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_FILL,
    S_WB_LOAD,
    S_WB_HI,
    S_WB_LO,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [SDRAM_AW-1:0]   addr_q, addr_d;
  logic [BC_W-1:0]       bc_q, bc_d;
  logic [ADDR_WIDTH-1:0] wc_q, wc_d;
  logic [31:0]           hold_q, hold_d;
  logic                  hi_first_q, hi_first_d;
  logic [31:0]           word_now;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      bc_q       <= '0;
      wc_q       <= '0;
      hold_q     <= '0;
      hi_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      bc_q       <= bc_d;
      wc_q       <= wc_d;
      hold_q     <= hold_d;
      hi_first_q <= hi_first_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    bc_d       = bc_q;
    wc_d       = wc_q;
    hold_d     = hold_q;
    hi_first_d = (state_q == S_WB_LOAD);

    // The buffer read launched in WB_LOAD lands in the first WB_HI cycle; bypass it
    // straight to wr_data there and serve later cycles from the hold register.
    word_now   = hi_first_q ? bus.buf_do : hold_q;

    bus.fill_ack  = 1'b0;
    bus.wb_ack    = 1'b0;
    bus.busy      = (state_q != S_IDLE);
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = we_q;
    bus.cmd_addr  = addr_q;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.buf_addr  = '0;
    bus.buf_we    = 4'b0000;
    bus.buf_di    = '0;

    unique case (state_q)
      S_IDLE: begin
        // Writeback wins so a dirty line is evicted before its slot is refilled.
        if (bus.wb_req) begin
          we_d    = 1'b1;
          addr_d  = bus.line_addr & ~LOW_MASK;
          state_d = S_CMD;
        end else if (bus.fill_req) begin
          we_d    = 1'b0;
          addr_d  = bus.line_addr & ~LOW_MASK;
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        bus.cmd_valid = 1'b1;
        if (bus.cmd_ready) state_d = we_q ? S_WB_LOAD : S_FILL;
      end

      S_FILL: begin
        bus.buf_addr = bc_q[BC_W-1:1];
        if (bus.rd_valid) begin
          // Even beats carry the upper half of the 32-bit word.
          bus.buf_we = bc_q[0] ? 4'b0011 : 4'b1100;
          bus.buf_di = {bus.rd_data, bus.rd_data};
          bc_d       = bc_q + BC_W'(1);
          if (&bc_q) state_d = S_DONE;
        end
      end

      S_WB_LOAD: begin
        bus.buf_addr = wc_q;
        state_d      = S_WB_HI;
      end

      S_WB_HI: begin
        bus.buf_addr = wc_q;
        hold_d       = word_now;
        bus.wr_valid = 1'b1;
        bus.wr_data  = word_now[31:16];
        if (bus.wr_ready) state_d = S_WB_LO;
      end

      S_WB_LO: begin
        bus.buf_addr = wc_q;
        bus.wr_valid = 1'b1;
        bus.wr_data  = hold_q[15:0];
        if (bus.wr_ready) begin
          wc_d    = wc_q + ADDR_WIDTH'(1);
          state_d = (&wc_q) ? S_DONE : S_WB_LOAD;
        end
      end

      S_DONE: begin
        bus.fill_ack = ~we_q;
        bus.wb_ack   = we_q;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_line_xfer.sv
// Self-checking bench for sdram_line_xfer: fills, writebacks, request priority and
// mid-transfer reset, against a line-buffer model and expected-line arithmetic.
module tb_sdram_line_xfer;
  localparam int AW    = 3;
  localparam int SAW   = 24;
  localparam int WORDS = 1 << AW;
  localparam int BEATS = 2 * WORDS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_line_xfer_if #(.ADDR_WIDTH(AW), .SDRAM_AW(SAW)) bus ();

  sdram_line_xfer #(.ADDR_WIDTH(AW), .SDRAM_AW(SAW)) dut (
    .sdram_clk   (clk),
    .sdram_rst_n (rst_n),
    .bus         (bus)
  );

  int tests = 0;
  int fails = 0;

  // Dual-port line buffer model: registered address, unregistered read data.
  logic [31:0]   mem [WORDS];
  logic [AW-1:0] addr_r;
  logic          pl_we   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else begin
      for (int b = 0; b < 4; b++)
        if (bus.buf_we[b]) mem[bus.buf_addr][8*b +: 8] <= bus.buf_di[8*b +: 8];
    end
    addr_r <= bus.buf_addr;
  end
  assign bus.buf_do = mem[addr_r];

  // Passive monitors.
  int          cyc = 0, n_writes = 0, n_fill_ack = 0, n_wb_ack = 0;
  int          stab_err = 0, last_beat_cyc = 0, acc_cyc = 0;
  logic [15:0] beats_q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.buf_we != 4'b0000) n_writes <= n_writes + 1;
    if (bus.fill_ack === 1'b1) n_fill_ack <= n_fill_ack + 1;
    if (bus.wb_ack === 1'b1) n_wb_ack <= n_wb_ack + 1;
    if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
      beats_q.push_back(bus.wr_data);
      last_beat_cyc <= cyc;
    end
    if (prev_stall && (bus.wr_valid !== 1'b1 || bus.wr_data !== prev_data))
      stab_err <= stab_err + 1;
    prev_stall <= (bus.wr_valid === 1'b1) && (bus.wr_ready !== 1'b1);
    prev_data  <= bus.wr_data;
  end

  logic [15:0] beat_buf [BEATS];
  logic [31:0] word_buf [WORDS];

  function automatic logic [SAW-1:0] line_base(input logic [SAW-1:0] a);
    return (a >> (AW + 2)) << (AW + 2);
  endfunction

  function automatic logic [94:0] out_vec();
    return {bus.fill_ack, bus.wb_ack, bus.busy, bus.cmd_valid, bus.cmd_we, bus.cmd_addr,
            bus.wr_valid, bus.wr_data, bus.buf_addr, bus.buf_we, bus.buf_di};
  endfunction

  task automatic clear_inputs();
    bus.fill_req  = 1'b0;
    bus.wb_req    = 1'b0;
    bus.line_addr = '0;
    bus.cmd_ready = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rd_data   = '0;
    bus.wr_ready  = 1'b0;
  endtask

  task automatic cmd_handshake(input int delay, input logic exp_we, input logic [SAW-1:0] exp_addr);
    int n = 0;
    int held = 0;
    while (bus.cmd_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.cmd_valid !== 1'b1) begin
      fails++;
      $display("FAIL cmd_wait: cmd_valid=%b, required 1 within 50 cycles", bus.cmd_valid);
    end
    for (int d = 0; d <= delay; d++) begin
      if (bus.cmd_valid === 1'b1) held++;
      if (d == delay) begin
        tests++;
        if (bus.cmd_we !== exp_we || bus.cmd_addr !== exp_addr) begin
          fails++;
          $display("FAIL cmd_fields: we=%b addr=%h, required we=%b addr=%h",
                   bus.cmd_we, bus.cmd_addr, exp_we, exp_addr);
        end
        bus.cmd_ready = 1'b1;
        acc_cyc = cyc;
      end
      @(negedge clk);
    end
    bus.cmd_ready = 1'b0;
    tests++;
    if (held != delay + 1 || bus.cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL cmd_hold: held %0d cycles, valid after accept=%b, required %0d and 0",
               held, bus.cmd_valid, delay + 1);
    end
  endtask

  task automatic fill_stream(input bit gap);
    int w0 = n_writes;
    int a0 = n_fill_ack;
    for (int i = 0; i < BEATS; i++) begin
      bus.rd_valid = 1'b1;
      bus.rd_data  = beat_buf[i];
      @(negedge clk);
      bus.rd_valid = 1'b0;
      bus.rd_data  = '0;
      if (gap && i != BEATS - 1) @(negedge clk);
    end
    tests++;
    if (bus.fill_ack !== 1'b1) begin
      fails++;
      $display("FAIL fill_ack_timing: fill_ack=%b one cycle after last beat, required 1", bus.fill_ack);
    end
    bus.fill_req = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.fill_ack !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL fill_end: fill_ack=%b busy=%b, required 0 0", bus.fill_ack, bus.busy);
    end
    tests++;
    if (n_writes - w0 != BEATS || n_fill_ack - a0 != 1) begin
      fails++;
      $display("FAIL fill_counts: writes=%0d acks=%0d, required %0d and 1",
               n_writes - w0, n_fill_ack - a0, BEATS);
    end
    for (int k = 0; k < WORDS; k++) begin
      tests++;
      if (mem[k] !== {beat_buf[2*k], beat_buf[2*k+1]}) begin
        fails++;
        $display("FAIL fill_word%0d: got %h, required %h", k, mem[k], {beat_buf[2*k], beat_buf[2*k+1]});
      end
    end
  endtask

  task automatic preload();
    for (int k = 0; k < WORDS; k++) begin
      pl_we   = 1'b1;
      pl_addr = AW'(k);
      pl_data = word_buf[k];
      @(negedge clk);
    end
    pl_we = 1'b0;
  endtask

  task automatic wb_stream(input bit rand_ready);
    int s0 = stab_err;
    int a0 = n_wb_ack;
    int n  = 0;
    beats_q.delete();
    while (bus.wb_ack !== 1'b1 && n < 400) begin
      bus.wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.wb_ack !== 1'b1) begin
      fails++;
      $display("FAIL wb_ack_wait: wb_ack=%b, required 1 within 400 cycles", bus.wb_ack);
    end
    bus.wb_req   = 1'b0;
    bus.wr_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.wb_ack !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL wb_end: wb_ack=%b busy=%b, required 0 0", bus.wb_ack, bus.busy);
    end
    tests++;
    if (beats_q.size() != BEATS) begin
      fails++;
      $display("FAIL wb_beat_count: got %0d beats, required %0d", beats_q.size(), BEATS);
    end
    for (int i = 0; i < BEATS && i < beats_q.size(); i++) begin
      logic [15:0] exp;
      exp = (i % 2 == 0) ? word_buf[i/2][31:16] : word_buf[i/2][15:0];
      tests++;
      if (beats_q[i] !== exp) begin
        fails++;
        $display("FAIL wb_beat%0d: got %h, required %h", i, beats_q[i], exp);
      end
    end
    if (!rand_ready) begin
      tests++;
      if (last_beat_cyc - acc_cyc != 3 * WORDS) begin
        fails++;
        $display("FAIL wb_latency: %0d cycles accept to last beat, required %0d",
                 last_beat_cyc - acc_cyc, 3 * WORDS);
      end
    end
    tests++;
    if (stab_err != s0 || n_wb_ack - a0 != 1) begin
      fails++;
      $display("FAIL wb_stability: stall violations=%0d acks=%0d, required 0 and 1",
               stab_err - s0, n_wb_ack - a0);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (out_vec() !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 0", out_vec());
    end
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b with no request, required 0", bus.busy);
    end
  endtask

  task automatic test_fill_basic();
    bus.line_addr = 24'h000123;
    for (int i = 0; i < BEATS; i++) beat_buf[i] = 16'(16'h1000 + i);
    bus.fill_req = 1'b1;
    cmd_handshake(0, 1'b0, 24'h000120);
    fill_stream(1'b0);
  endtask

  task automatic test_fill_random();
    logic [SAW-1:0] la = SAW'($urandom);
    bus.line_addr = la;
    for (int i = 0; i < BEATS; i++) beat_buf[i] = 16'($urandom);
    bus.fill_req = 1'b1;
    cmd_handshake(int'($urandom_range(0, 3)), 1'b0, line_base(la));
    fill_stream(1'b0);
  endtask

  task automatic test_fill_gapped();
    logic [SAW-1:0] la = SAW'($urandom);
    bus.line_addr = la;
    for (int i = 0; i < BEATS; i++) beat_buf[i] = 16'(16'h1000 + i);
    bus.fill_req = 1'b1;
    cmd_handshake(5, 1'b0, line_base(la));
    fill_stream(1'b1);
  endtask

  task automatic test_writeback(input bit rand_words, input bit rand_ready);
    logic [SAW-1:0] la = SAW'($urandom);
    for (int k = 0; k < WORDS; k++) word_buf[k] = rand_words ? $urandom : 32'hA0B0C0D0 + 32'(k);
    preload();
    bus.line_addr = la;
    bus.wb_req    = 1'b1;
    cmd_handshake(0, 1'b1, line_base(la));
    wb_stream(rand_ready);
  endtask

  task automatic test_priority();
    logic [SAW-1:0] la = SAW'($urandom);
    for (int k = 0; k < WORDS; k++) word_buf[k] = $urandom;
    for (int i = 0; i < BEATS; i++) beat_buf[i] = 16'($urandom);
    preload();
    bus.line_addr = la;
    bus.fill_req  = 1'b1;
    bus.wb_req    = 1'b1;
    cmd_handshake(0, 1'b1, line_base(la));
    wb_stream(1'b0);
    cmd_handshake(0, 1'b0, line_base(la));
    fill_stream(1'b0);
  endtask

  task automatic test_reset_mid_fill();
    logic [SAW-1:0] la = SAW'($urandom);
    int w0, a0;
    bus.line_addr = la;
    bus.fill_req  = 1'b1;
    cmd_handshake(0, 1'b0, line_base(la));
    w0 = n_writes;
    a0 = n_fill_ack + n_wb_ack;
    for (int i = 0; i < 5; i++) begin
      bus.rd_valid = 1'b1;
      bus.rd_data  = 16'($urandom);
      @(negedge clk);
    end
    bus.rd_valid = 1'b0;
    bus.fill_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (out_vec() !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got %h, required 0", out_vec());
    end
    for (int i = 5; i < BEATS; i++) begin
      bus.rd_valid = 1'b1;
      bus.rd_data  = 16'($urandom);
      @(negedge clk);
    end
    bus.rd_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (n_writes - w0 != 5 || n_fill_ack + n_wb_ack != a0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_stray: writes=%0d extra acks=%0d busy=%b, required 5 0 0",
               n_writes - w0, n_fill_ack + n_wb_ack - a0, bus.busy);
    end
    test_fill_random();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_basic();
    test_fill_random();
    test_fill_gapped();
    test_writeback(1'b0, 1'b0);
    test_writeback(1'b0, 1'b1);
    test_writeback(1'b1, 1'b1);
    test_priority();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
